// File: rtl/uart_pkg.sv
// Shared constants, state encodings and frame helpers for the parametrised UART.
package uart_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START_CHK,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    function automatic int unsigned frame_bits(input int unsigned data_bits,
                                               input int unsigned parity,
                                               input int unsigned stop_bits);
        return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_param_if.sv
// Bus-side handshake and payload signals of the UART.
interface uart_param_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 start;
    logic [DATA_BITS-1:0] tx_data_in;
    logic                 tx_ready;
    logic [DATA_BITS-1:0] rx_data_out;
    logic                 rx_ready;
    logic                 rx_parity_err;
    logic                 rx_frame_err;

    modport master (
        output start, tx_data_in,
        input  tx_ready, rx_data_out, rx_ready, rx_parity_err, rx_frame_err
    );

    modport slave (
        input  start, tx_data_in,
        output tx_ready, rx_data_out, rx_ready, rx_parity_err, rx_frame_err
    );
endinterface

// File: rtl/uart_rx_param.sv
// UART receiver: 2-flop synchroniser, start-bit validation, mid-bit sampling, error flags.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 ready,
    output logic                 parity_err,
    output logic                 frame_err
);

    localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W    = $clog2(DATA_BITS);
    localparam logic        HAS_PAR  = (PARITY != PAR_NONE);
    localparam logic        ODD_FLAG = (PARITY == PAR_ODD);

    if (CLKS_PER_BIT < 4 || (CLKS_PER_BIT % 2) != 0 || DATA_BITS < 5 || DATA_BITS > 9 ||
        PARITY > PAR_EVEN || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_param
        $fatal(1, "uart_rx_param: illegal parameter set");
    end

    rx_state_e            state, state_next;
    logic                 sync1, rx_s, rx_prev;
    logic [CNT_W-1:0]     cnt, cnt_next;
    logic [BIT_W-1:0]     bit_cnt, bit_cnt_next;
    logic [DATA_BITS-1:0] shreg, shreg_next;
    logic                 par_q, par_next;
    logic                 half_tick, full_tick;
    logic                 done_c, perr_c, ferr_c;

    assign half_tick = (cnt == CNT_W'(CLKS_PER_BIT / 2 - 1));
    assign full_tick = (cnt == CNT_W'(CLKS_PER_BIT - 1));

    // Line is assumed idle-high out of reset so no false edge is seen
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            sync1   <= rx;
            rx_s    <= sync1;
            rx_prev <= rx_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RX_IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            par_q   <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            bit_cnt <= bit_cnt_next;
            shreg   <= shreg_next;
            par_q   <= par_next;
        end
    end

    always_comb begin
        state_next   = state;
        cnt_next     = cnt + 1'b1;
        bit_cnt_next = bit_cnt;
        shreg_next   = shreg;
        par_next     = par_q;
        case (state)
            RX_IDLE: begin
                cnt_next = '0;
                if (rx_prev && !rx_s) state_next = RX_START_CHK;
            end
            RX_START_CHK: if (half_tick) begin
                cnt_next     = '0;
                bit_cnt_next = '0;
                state_next   = rx_s ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (full_tick) begin
                cnt_next   = '0;
                shreg_next = {rx_s, shreg[DATA_BITS-1:1]};
                if (bit_cnt == BIT_W'(DATA_BITS - 1))
                    state_next = HAS_PAR ? RX_PARITY : RX_STOP;
                else
                    bit_cnt_next = bit_cnt + 1'b1;
            end
            RX_PARITY: if (full_tick) begin
                cnt_next   = '0;
                par_next   = rx_s;
                state_next = RX_STOP;
            end
            // Only the first stop bit is checked so back-to-back frames are accepted
            RX_STOP: if (full_tick) begin
                cnt_next   = '0;
                state_next = RX_IDLE;
            end
            default: state_next = RX_IDLE;
        endcase
    end

    always_comb begin
        done_c = (state == RX_STOP) && full_tick;
        ferr_c = !rx_s;
        perr_c = HAS_PAR && ((^shreg) ^ par_q ^ ODD_FLAG);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out   <= '0;
            ready      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            ready <= done_c;
            if (done_c) begin
                data_out   <= shreg;
                parity_err <= perr_c;
                frame_err  <= ferr_c;
            end
        end
    end

endmodule

// File: rtl/uart_param.sv
// Parametrised full-duplex UART: transmitter FSM here, receiver in uart_rx_param.
module uart_param
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic         clk,
    input  logic         rst,
    uart_param_if.slave  bus,
    output logic         tx,
    input  logic         rx
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W = $clog2(DATA_BITS);

    if (CLKS_PER_BIT < 4 || (CLKS_PER_BIT % 2) != 0 || DATA_BITS < 5 || DATA_BITS > 9 ||
        PARITY > PAR_EVEN || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_param
        $fatal(1, "uart_param: illegal parameter set");
    end

    tx_state_e            state, state_next;
    logic [CNT_W-1:0]     clk_cnt, clk_cnt_next;
    logic [BIT_W-1:0]     bit_cnt, bit_cnt_next;
    logic                 stop_cnt, stop_cnt_next;
    logic [DATA_BITS-1:0] data_q, data_next;
    logic                 tick, par_bit;
    logic                 tx_c, tx_ready_c;

    assign tick    = (clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign par_bit = (PARITY == PAR_ODD) ? ~(^data_q) : (^data_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= TX_IDLE;
            clk_cnt  <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            data_q   <= '0;
        end else begin
            state    <= state_next;
            clk_cnt  <= clk_cnt_next;
            bit_cnt  <= bit_cnt_next;
            stop_cnt <= stop_cnt_next;
            data_q   <= data_next;
        end
    end

    always_comb begin
        state_next    = state;
        clk_cnt_next  = tick ? '0 : clk_cnt + 1'b1;
        bit_cnt_next  = bit_cnt;
        stop_cnt_next = stop_cnt;
        data_next     = data_q;
        case (state)
            TX_IDLE: begin
                clk_cnt_next = '0;
                if (bus.start) begin
                    state_next    = TX_START;
                    data_next     = bus.tx_data_in;
                    bit_cnt_next  = '0;
                    stop_cnt_next = 1'b0;
                end
            end
            TX_START: if (tick) state_next = TX_DATA;
            TX_DATA: if (tick) begin
                if (bit_cnt == BIT_W'(DATA_BITS - 1))
                    state_next = (PARITY == PAR_NONE) ? TX_STOP : TX_PARITY;
                else
                    bit_cnt_next = bit_cnt + 1'b1;
            end
            TX_PARITY: if (tick) state_next = TX_STOP;
            TX_STOP: if (tick) begin
                if (stop_cnt == 1'(STOP_BITS - 1))
                    state_next = TX_IDLE;
                else
                    stop_cnt_next = 1'b1;
            end
            default: state_next = TX_IDLE;
        endcase
    end

    // Decoded from the next state so the registered pins change on the transition edge
    always_comb begin
        tx_c       = 1'b1;
        tx_ready_c = 1'b0;
        case (state_next)
            TX_IDLE:   tx_ready_c = 1'b1;
            TX_START:  tx_c = 1'b0;
            TX_DATA:   tx_c = data_q[bit_cnt_next];
            TX_PARITY: tx_c = par_bit;
            TX_STOP:   tx_c = 1'b1;
            default:   tx_c = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx           <= 1'b1;
            bus.tx_ready <= 1'b1;
        end else begin
            tx           <= tx_c;
            bus.tx_ready <= tx_ready_c;
        end
    end

    uart_rx_param #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .DATA_BITS    (DATA_BITS),
        .PARITY       (PARITY),
        .STOP_BITS    (STOP_BITS)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .data_out   (bus.rx_data_out),
        .ready      (bus.rx_ready),
        .parity_err (bus.rx_parity_err),
        .frame_err  (bus.rx_frame_err)
    );

endmodule

// File: tb/tb_uart_param.sv
// Scoreboard bench: three UART configurations (8N1/16, 7E2/8, 8O1/8), loopback and driven frames.
module tb_uart_param;

    typedef struct packed {
        logic [8:0] data;
        logic       pe;
        logic       fe;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] start_v;
    logic [8:0] din_v [3];
    logic [2:0] tx_v, rdy_v, rxr_v, pe_v, fe_v;
    logic [8:0] rxd_v [3];
    logic [2:0] drv_en, rx_drv, rx_line, prev_rdy;

    exp_t exp_q [3][$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    assign rx_line = (drv_en & rx_drv) | (~drv_en & tx_v);

    uart_param_if #(.DATA_BITS(8)) bus_a ();
    uart_param_if #(.DATA_BITS(7)) bus_b ();
    uart_param_if #(.DATA_BITS(8)) bus_c ();

    uart_param #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a), .tx(tx_v[0]), .rx(rx_line[0]));
    uart_param #(.CLKS_PER_BIT(8), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b), .tx(tx_v[1]), .rx(rx_line[1]));
    uart_param #(.CLKS_PER_BIT(8), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut_c (
        .clk(clk), .rst(rst), .bus(bus_c), .tx(tx_v[2]), .rx(rx_line[2]));

    assign bus_a.start      = start_v[0];
    assign bus_b.start      = start_v[1];
    assign bus_c.start      = start_v[2];
    assign bus_a.tx_data_in = din_v[0][7:0];
    assign bus_b.tx_data_in = din_v[1][6:0];
    assign bus_c.tx_data_in = din_v[2][7:0];

    assign rdy_v = {bus_c.tx_ready, bus_b.tx_ready, bus_a.tx_ready};
    assign rxr_v = {bus_c.rx_ready, bus_b.rx_ready, bus_a.rx_ready};
    assign pe_v  = {bus_c.rx_parity_err, bus_b.rx_parity_err, bus_a.rx_parity_err};
    assign fe_v  = {bus_c.rx_frame_err, bus_b.rx_frame_err, bus_a.rx_frame_err};
    assign rxd_v[0] = {1'b0, bus_a.rx_data_out};
    assign rxd_v[1] = {2'b00, bus_b.rx_data_out};
    assign rxd_v[2] = {1'b0, bus_c.rx_data_out};

    // Per-instance configuration, straight from the frame rules
    function automatic int cpb(input int i);   return (i == 0) ? 16 : 8;                endfunction
    function automatic int dbits(input int i); return (i == 1) ? 7 : 8;                 endfunction
    function automatic int pmode(input int i); return (i == 0) ? 0 : ((i == 1) ? 2 : 1); endfunction
    function automatic int nstop(input int i); return (i == 1) ? 2 : 1;                 endfunction
    function automatic int fbits(input int i);
        return 1 + dbits(i) + ((pmode(i) != 0) ? 1 : 0) + nstop(i);
    endfunction

    task automatic check(input string name, input int inst, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s inst%0d: got 0x%0h, expected 0x%0h at %0t", name, inst, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name, input int inst);
        checks++;
        errors++;
        $display("FAIL %s inst%0d: timed out waiting at %0t", name, inst, $time);
    endtask

    // Monitor: pops the scoreboard whenever a frame is reported
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            if (rxr_v[i]) begin
                check("rx_ready_single", i, int'(prev_rdy[i]), 0);
                if (exp_q[i].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_unexpected inst%0d: got frame 0x%0h, expected none at %0t",
                             i, rxd_v[i], $time);
                end else begin
                    e = exp_q[i].pop_front();
                    check("rx_data", i, int'(rxd_v[i]), int'(e.data));
                    check("rx_parity_err", i, int'(pe_v[i]), int'(e.pe));
                    check("rx_frame_err", i, int'(fe_v[i]), int'(e.fe));
                end
            end
        end
        prev_rdy = rxr_v;
    end

    task automatic send(input int i, input logic [8:0] d, input bit poke_busy);
        int n;
        n = 0;
        while (!rdy_v[i] && n < 5000) begin @(negedge clk); n++; end
        if (!rdy_v[i]) begin timeout("tx_ready_wait", i); return; end
        din_v[i]   = d;
        start_v[i] = 1'b1;
        exp_q[i].push_back(exp_t'{d, 1'b0, 1'b0});
        @(negedge clk);
        start_v[i] = 1'b0;
        check("tx_start_bit", i, int'(tx_v[i]), 0);
        n = 0;
        while (!rdy_v[i] && n < 5000) begin
            n++;
            if (poke_busy && n == 40) begin
                start_v[i] = 1'b1;
                din_v[i]   = ~d;
            end else begin
                start_v[i] = 1'b0;
            end
            @(negedge clk);
        end
        start_v[i] = 1'b0;
        check("tx_busy_cycles", i, n, fbits(i) * cpb(i));
    endtask

    task automatic hold(input int i, input logic v, input int c);
        rx_drv[i] = v;
        repeat (c) @(negedge clk);
    endtask

    task automatic drive_frame(input int i, input logic [8:0] d, input bit bad_par, input bit stop_low);
        int   ones;
        logic pb;
        exp_q[i].push_back(exp_t'{d, logic'(bad_par && pmode(i) != 0), logic'(stop_low)});
        drv_en[i] = 1'b1;
        hold(i, 1'b0, cpb(i));
        for (int b = 0; b < dbits(i); b++) hold(i, d[b], cpb(i));
        if (pmode(i) != 0) begin
            ones = $countones(d);
            pb   = (pmode(i) == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
            hold(i, pb ^ bad_par, cpb(i));
        end
        hold(i, ~stop_low, cpb(i));
        if (nstop(i) == 2) hold(i, 1'b1, cpb(i));
        hold(i, 1'b1, 2 * cpb(i));
        drv_en[i] = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 3; i++)
            if (exp_q[i].size() != 0) begin
                timeout("rx_frame_missing", i);
                exp_q[i].delete();
            end
        repeat (8) @(negedge clk);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        start_v  = '0;
        drv_en   = '0;
        rx_drv   = '1;
        prev_rdy = '0;
        for (int i = 0; i < 3; i++) din_v[i] = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("rst_tx", i, int'(tx_v[i]), 1);
            check("rst_tx_ready", i, int'(rdy_v[i]), 1);
            check("rst_rx_ready", i, int'(rxr_v[i]), 0);
            check("rst_rx_data", i, int'(rxd_v[i]), 0);
            check("rst_parity_err", i, int'(pe_v[i]), 0);
            check("rst_frame_err", i, int'(fe_v[i]), 0);
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);

        send(0, 9'h0A5, 1'b0);
        drain();

        send(1, 9'h055, 1'b0);
        send(1, 9'h07F, 1'b0);
        drain();

        drive_frame(2, 9'h03C, 1'b1, 1'b0);
        drive_frame(2, 9'h03C, 1'b0, 1'b0);
        drain();

        // Short low glitch must not produce a frame
        drv_en[0] = 1'b1;
        hold(0, 1'b0, 3 * 16 / 8);
        hold(0, 1'b1, 64);
        drive_frame(0, 9'h081, 1'b0, 1'b0);
        drain();

        drive_frame(0, 9'h0FF, 1'b0, 1'b1);
        drain();

        // Break: one frame of zeros with a framing error, then re-arm on high
        exp_q[0].push_back(exp_t'{9'h000, 1'b0, 1'b1});
        drv_en[0] = 1'b1;
        hold(0, 1'b0, 20 * 16);
        hold(0, 1'b1, 32);
        drv_en[0] = 1'b0;
        drain();

        send(0, 9'h03C, 1'b1);
        drain();

        fork
            begin for (int k = 0; k < 4; k++) send(0, 9'($urandom_range(0, 255)), 1'b0); end
            begin for (int k = 0; k < 5; k++) send(1, 9'($urandom_range(0, 127)), 1'b0); end
            begin for (int k = 0; k < 5; k++) send(2, 9'($urandom_range(0, 255)), 1'b0); end
        join
        drain();

        for (int k = 0; k < 4; k++)
            drive_frame(2, 9'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        drain();

        // Reset in the middle of a data bit on both directions of instance A
        din_v[0]   = 9'h0C3;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (60) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_tx", 0, int'(tx_v[0]), 1);
        check("rst_mid_tx_ready", 0, int'(rdy_v[0]), 1);
        check("rst_mid_rx_ready", 0, int'(rxr_v[0]), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        send(0, 9'h012, 1'b0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
